// File: rtl/tick_ctrl.sv
// tick_ctrl: programmable prescaler that emits single-cycle tick enables
// at a configured period, either for a fixed number of ticks or forever.
// Slow-rate consumers use tick as a clock enable instead of a derived clock.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | no run active; configuration port open (cfg_ready = 1)
// S_RUN   | prescale counter advancing, ticks emitted at terminal count
// S_PAUSE | run frozen by hold; counter keeps its value until hold drops
module tick_ctrl #(
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned DEFAULT_PERIOD = 50_000_000,
  parameter int unsigned CNT_MAX_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CNT_W-1:0]     cfg_period,
  input  logic [CNT_MAX_W-1:0] cfg_count,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 hold,
  output logic                 tick,
  output logic                 done,
  output logic                 busy,
  output logic [CNT_MAX_W-1:0] ticks_left
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_t;

  // A period of 0 would make the terminal-count compare wrap, so it is
  // stored as 1; the compare against period-1 then never underflows.
  function automatic logic [CNT_W-1:0] clamp_period(input logic [CNT_W-1:0] p);
    return (p == '0) ? CNT_W'(1) : p;
  endfunction

  localparam logic [CNT_W-1:0] DEF_PERIOD_RAW = CNT_W'(DEFAULT_PERIOD);
  localparam logic [CNT_W-1:0] DEF_PERIOD     = (DEF_PERIOD_RAW == '0) ? CNT_W'(1)
                                                                       : DEF_PERIOD_RAW;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     period_q, period_d;
  logic [CNT_MAX_W-1:0] count_q, count_d;
  logic [CNT_MAX_W-1:0] left_q, left_d;
  logic                 tick_q, tick_d;
  logic                 done_q, done_d;

  logic                 cfg_hs;
  logic                 at_tc;
  logic                 counted;

  assign cfg_ready  = (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign tick       = tick_q;
  assign done       = done_q;
  assign ticks_left = left_q;

  assign cfg_hs  = cfg_valid & cfg_ready;
  // period_q is never 0, so period_q-1 is always a valid count value.
  assign at_tc   = (cnt_q == (period_q - CNT_W'(1)));
  // ticks_left is only nonzero during a counted run; 0 marks continuous mode.
  assign counted = (left_q != '0);

  // Next-state, counter and pulse logic; pulses default low every edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    count_d  = count_q;
    left_d   = left_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cfg_hs) begin
          period_d = clamp_period(cfg_period);
          count_d  = cfg_count;
        end
        if (start && !stop) begin
          state_d = S_RUN;
          cnt_d   = '0;
          // A handshake on the same edge supplies the count for this run.
          left_d  = cfg_hs ? cfg_count : count_q;
        end
      end

      S_RUN: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          left_d  = '0;
        end else if (hold) begin
          state_d = S_PAUSE;
        end else if (at_tc) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (counted) begin
            if (left_q == CNT_MAX_W'(1)) begin
              left_d  = '0;
              done_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              left_d = left_q - CNT_MAX_W'(1);
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_PAUSE: begin
        if (stop) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          left_d  = '0;
        end else if (!hold) begin
          // Resume edge does not count; counting restarts on the next edge.
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        left_d  = '0;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= DEF_PERIOD;
      count_q  <= '0;
      left_q   <= '0;
      tick_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      count_q  <= count_d;
      left_q   <= left_d;
      tick_q   <= tick_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_tick_ctrl.sv
// Testbench for tick_ctrl: a driver applies one set of inputs per clock
// and pushes the reference model's expected outputs into a queue; a
// monitor pops one entry per cycle on the falling edge and compares.
module tb_tick_ctrl;

  localparam int CNT_W     = 16;
  localparam int DEF_P     = 7;
  localparam int CNT_MAX_W = 8;

  logic                 clk;
  logic                 rst_n;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CNT_W-1:0]     cfg_period;
  logic [CNT_MAX_W-1:0] cfg_count;
  logic                 start;
  logic                 stop;
  logic                 hold;
  logic                 tick;
  logic                 done;
  logic                 busy;
  logic [CNT_MAX_W-1:0] ticks_left;

  tick_ctrl #(
    .CNT_W          (CNT_W),
    .DEFAULT_PERIOD (DEF_P),
    .CNT_MAX_W      (CNT_MAX_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_count  (cfg_count),
    .start      (start),
    .stop       (stop),
    .hold       (hold),
    .tick       (tick),
    .done       (done),
    .busy       (busy),
    .ticks_left (ticks_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit tick;
    bit done;
    bit busy;
    bit ready;
    int left;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Behavioural reference: a run is "active" or "idle"; while active it
  // may be paused. elapsed counts the counting edges since the last tick.
  bit m_active;
  bit m_paused;
  int m_elapsed;
  int m_period;
  int m_count;
  int m_left;
  bit m_tick;
  bit m_done;

  task automatic model_edge(input bit r, input bit st, input bit sp, input bit hd,
                            input bit cv, input int cp, input int cc);
    m_tick = 0;
    m_done = 0;
    if (!r) begin
      m_active  = 0;
      m_paused  = 0;
      m_elapsed = 0;
      m_period  = DEF_P;
      m_count   = 0;
      m_left    = 0;
    end else if (!m_active) begin
      if (cv) begin
        m_period = (cp == 0) ? 1 : cp;
        m_count  = cc;
      end
      if (st && !sp) begin
        m_active  = 1;
        m_paused  = 0;
        m_elapsed = 0;
        m_left    = m_count;
      end
    end else if (sp) begin
      m_active  = 0;
      m_paused  = 0;
      m_elapsed = 0;
      m_left    = 0;
    end else if (m_paused) begin
      if (!hd) m_paused = 0;
    end else if (hd) begin
      m_paused = 1;
    end else begin
      m_elapsed++;
      if (m_elapsed == m_period) begin
        m_elapsed = 0;
        m_tick    = 1;
        if (m_left == 1) begin
          m_left   = 0;
          m_done   = 1;
          m_active = 0;
        end else if (m_left > 1) begin
          m_left--;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit st, input bit sp, input bit hd,
                      input bit cv, input int cp, input int cc);
    exp_t e;
    rst_n      = r;
    start      = st;
    stop       = sp;
    hold       = hd;
    cfg_valid  = cv;
    cfg_period = CNT_W'(cp);
    cfg_count  = CNT_MAX_W'(cc);
    model_edge(r, st, sp, hd, cv, cp, cc);
    e.tick  = m_tick;
    e.done  = m_done;
    e.busy  = m_active;
    e.ready = !m_active;
    e.left  = m_left;
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("tick",       {31'd0, tick},      {31'd0, e.tick});
      chk("done",       {31'd0, done},      {31'd0, e.done});
      chk("busy",       {31'd0, busy},      {31'd0, e.busy});
      chk("cfg_ready",  {31'd0, cfg_ready}, {31'd0, e.ready});
      chk("ticks_left", {24'd0, ticks_left}, 32'(e.left));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog at %0t: got timeout expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with inputs low
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(2);

    // Counted run: period 4, count 3
    step(1, 0, 0, 0, 1, 4, 3);
    step(1, 1, 0, 0, 0, 0, 0);
    idle(16);

    // Continuous period 1, then stop
    step(1, 1, 0, 0, 1, 1, 0);
    idle(6);
    step(1, 0, 1, 0, 0, 0, 0);
    idle(3);

    // Hold at counter 2 of period 5; two held edges plus the resume edge
    step(1, 1, 0, 0, 1, 5, 2);
    idle(2);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    idle(14);

    // Stop on the terminal-count edge
    step(1, 1, 0, 0, 1, 3, 1);
    idle(2);
    step(1, 0, 1, 0, 0, 0, 0);
    idle(4);

    // start and stop together in IDLE
    step(1, 1, 1, 0, 0, 0, 0);
    idle(3);

    // Config offered during a run is refused
    step(1, 1, 0, 0, 1, 3, 2);
    step(1, 0, 0, 0, 1, 9, 4);
    idle(8);
    step(1, 1, 0, 0, 0, 0, 0);
    idle(8);

    // Period 0 behaves as period 1
    step(1, 1, 0, 0, 1, 0, 1);
    idle(3);

    // Reset mid-run at counter 3 of period 6, then run on the default period
    step(1, 1, 0, 0, 1, 6, 0);
    idle(3);
    step(0, 0, 0, 0, 0, 0, 0);
    idle(2);
    step(1, 1, 0, 0, 0, 0, 0);
    idle(16);
    step(1, 0, 1, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 99) > 1,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) == 0,
           int'($urandom_range(0, 6)),
           int'($urandom_range(0, 4)));
    end
    idle(4);

    @(negedge clk);
    #1;
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
